// File: rtl/mul_seq.sv
// mul_seq: iterative 32x32 multiplier for the M-extension mul/mulh/mulhu ops.
// A radix-2 shift-add engine retires one multiplier bit per cycle (LSB first).
// Signed mulh works on operand magnitudes and negates the 64-bit product at the end.
// Each operation is one launch cycle in IDLE, then 32 BUSY cycles, then one DONE cycle.
//
// Ports
//   clk    : single clock; all state changes on the rising edge
//   rst    : synchronous reset, active high
//   start  : M-extension instruction present; sampled only in IDLE
//   op     : 00 mul (low word), 01 mulh (signed, high word),
//            11 mulhu (unsigned, high word), 10 reserved (treated as mul)
//   a, b   : rs1 / rs2 operands; captured at launch
//   stall  : holds PC/fetch and suppresses regwrite; combinational
//   done   : one-cycle pulse in DONE; result is valid for writeback
//   result : selected product word; held until the next DONE or reset
module mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [63:0] mcand;     // multiplicand, shifted left one bit per step
    logic [31:0] mplier;    // multiplier, shifted right one bit per step
    logic        neg;       // product must be negated (mulh with opposite signs)
    logic        hi;        // select high product word

    logic        signed_op;
    logic [31:0] mag_a, mag_b;
    logic [63:0] acc_nxt, prod;

    // Only mulh is signed. The magnitude of 0x80000000 is 0x80000000, which is
    // correct when it is read as unsigned.
    assign signed_op = (op == 2'b01);
    assign mag_a     = (signed_op && a[31]) ? (~a + 32'd1) : a;
    assign mag_b     = (signed_op && b[31]) ? (~b + 32'd1) : b;

    // On the final BUSY step acc_nxt is the full unsigned product.
    assign acc_nxt = acc + (mplier[0] ? mcand : 64'd0);
    assign prod    = neg ? (~acc_nxt + 64'd1) : acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    stall     = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (count == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset overrides the outputs, so an aborted op never pulses done or stalls.
        if (rst) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 5'd0;
            acc    <= 64'd0;
            mcand  <= 64'd0;
            mplier <= 32'd0;
            neg    <= 1'b0;
            hi     <= 1'b0;
            result <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count  <= 5'd0;
                        acc    <= 64'd0;
                        mcand  <= {32'd0, mag_a};
                        mplier <= mag_b;
                        neg    <= signed_op & (a[31] ^ b[31]);
                        hi     <= op[0];
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= {mcand[62:0], 1'b0};
                    mplier <= {1'b0, mplier[31:1]};
                    count  <= count + 5'd1;
                    // Register the result as DONE is entered. It is then visible
                    // during the done pulse and held afterwards.
                    if (count == 5'd31)
                        result <= hi ? prod[63:32] : prod[31:0];
                end
                default: ;
            endcase
        end
    end

endmodule
